fp_helper_unit: RTL and testbench
=================================

Name: fp_helper_unit

Overview:
- Multi-cycle IEEE-754 single-precision helper for the series-iteration controller.
- Provides three operations on one start/done handshake:
  - FRAC: checks whether n has a fractional part.
  - SQR: computes x*x.
  - DIV: computes x/n.
- The controller starts one operation at a time with a one-cycle r_i pulse and waits for a one-cycle r_o pulse.

Parameters:
None.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
r_i  in  1  start strobe; sampled only when busy=0
op  in  2  operation: 00 FRAC, 01 SQR, 10 DIV, 11 reserved (completes as FRAC)
x  in  32  float operand x
n  in  32  float operand n
res  out  32  float result (SQR/DIV); 0 for FRAC
frac  out  1  FRAC result: 1 = n is not an integer
err  out  1  SQR/DIV error flag
r_o  out  1  one-cycle done pulse
busy  out  1  operation in progress

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (low) values: res=0, frac=0, err=0, r_o=0, busy=0, FSM=IDLE.
- Reset mid-operation aborts the operation; no r_o is produced.
- Handshake and timing:
  - r_i high at edge k while IDLE: x, n and op are latched, and busy=1 from k.
  - r_o is high exactly for the cycle following edge k+L.
  - res, frac and err update at edge k+L and hold until the next completion.
  - busy drops together with r_o.
  - r_i while busy is ignored.
  - Operand changes after edge k have no effect.
- Latency L: FRAC 2, SQR 26, DIV 28.
- States: IDLE -> UNPACK -> ITER (FRAC skips) -> PACK -> DONE (r_o=1) -> IDLE.
- Number handling (all ops):
  - Denormal inputs are flushed to signed zero.
  - Underflowing results flush to +0 with err=0.
  - Rounding is toward zero unless the optional feature below is compiled in.
- FRAC (uses n only):
  - e = n[30:23].
  - Zero (either sign): frac=0.
  - e<127 and nonzero: frac=1.
  - 127<=e<150: frac=1 iff any of the low (150-e) mantissa bits are set.
  - 150<=e<255: frac=0.
  - e=255 (Inf/NaN): frac=1.
  - Sign is ignored; err=0.
- SQR (uses x only):
  - Sign of result is 0.
  - 24x24 shift-add multiply over 24 ITER cycles, then normalize.
  - Result exponent >254, or x Inf/NaN: err=1, res=0.
  - x=0: res=0.
- DIV (res = x/n):
  - Sign of result = x[31]^n[31].
  - Restoring division producing 26 quotient bits over 26 ITER cycles, then normalize.
  - n=0, or either operand Inf/NaN: err=1, res=0.
  - x=0 (n nonzero): res=0.
  - Overflow: err=1, res=0.
- Exponent arithmetic uses 10-bit signed intermediates, so there is no wrap-around.

Optional Feature:
- Macro: FP_HELPER_ROUND_NEAREST_EN.
- Defined: SQR and DIV round to nearest, ties-to-even, using guard and sticky bits (DIV sticky = nonzero remainder).
  - A mantissa carry-out increments the exponent.
  - Rounding into exponent 255 sets err=1, res=0.
- Undefined: truncation (round toward zero).
- Latencies are identical in both builds.

Test Plan:
- FRAC n=0x40400000 (3.0) -> frac=0 at L=2; n=0x40200000 (2.5) -> frac=1; n=0x3F000000 (0.5) -> frac=1; n=0x00000000 -> frac=0.
- SQR x=0x40400000 -> res=0x41100000 (9.0), err=0, r_o 26 cycles after r_i; x=0x3FC00000 -> res=0x40100000 (2.25); x=0xC0000000 -> res=0x40800000.
- SQR x=0x60AD78EC (~1e20) -> err=1, res=0.
- DIV x=0x3F800000, n=0x40400000 -> res=0x3EAAAAAA (truncation) or 0x3EAAAAAB (ROUND_NEAREST_EN), r_o 28 cycles after r_i.
- DIV x=0x40A00000, n=0x00000000 -> err=1, res=0.
- DIV x=0x41200000, n=0xC0000000 -> res=0xC0A00000 (-5.0).
- Handshake/reset:
  - A second r_i pulse mid-SQR is ignored: exactly one r_o, with the first result.
  - reset pulled low at cycle 10 of a DIV -> no r_o, all outputs 0.
  - Next r_i after reset works normally.

Source files
------------

// File: rtl/fp_helper_unit_if.sv
// Start/done handshake and operand/result bus of the fp_helper_unit float helper.
interface fp_helper_unit_if;
  logic        r_i;
  logic [1:0]  op;
  logic [31:0] x;
  logic [31:0] n;
  logic [31:0] res;
  logic        frac;
  logic        err;
  logic        r_o;
  logic        busy;

  modport master (output r_i, op, x, n, input res, frac, err, r_o, busy);
  modport slave  (input r_i, op, x, n, output res, frac, err, r_o, busy);
endinterface

// File: rtl/fp_helper_unit.sv
// Multi-cycle single-precision helper: FRAC test, SQR (x*x), DIV (x/n), truncating by default.
// Define FP_HELPER_ROUND_NEAREST_EN for round-to-nearest-even on SQR/DIV.
module fp_helper_unit (
  input  logic          clk,
  input  logic          reset,
  fp_helper_unit_if.slave bus
);

`ifdef FP_HELPER_ROUND_NEAREST_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  typedef enum logic [2:0] {IDLE, UNPACK, ITER, PACK, DONE} state_t;

  state_t state, state_nxt;
  logic [4:0]  cnt_p1;
  logic [31:0] x_p0, n_p0;
  logic [1:0]  op_p0;
  logic        is_sqr, is_div;
  logic [7:0]  ex, en;
  logic [23:0] mx, mn;
  logic        sign_p1, zero_p1, bad_p1;
  logic signed [9:0] exp_p1;
  logic [47:0] acc_p1, mcand_p1;
  logic [23:0] mplier_p1, dvsr_p1;
  logic [25:0] rem_p1, quo_p1, div_rem;
  logic        div_ge;
  logic        hi, g, s;
  logic [22:0] mant;
  logic signed [9:0] e_n;
  logic [32:0] pk;
  logic [31:0] res_q;
  logic        frac_q, err_q, r_o_c, busy_c;

  function automatic logic frac_of(input logic [30:0] v);
    logic [7:0]  e;
    logic [7:0]  sh;
    logic [22:0] mask;
    e    = v[30:23];
    sh   = 8'd150 - e;
    mask = (23'd1 << sh) - 23'd1;
    if (e == 8'd0)        frac_of = 1'b0;
    else if (e < 8'd127)  frac_of = 1'b1;
    else if (e < 8'd150)  frac_of = |(v[22:0] & mask);
    else if (e < 8'd255)  frac_of = 1'b0;
    else                  frac_of = 1'b1;
  endfunction

  // Returns {err, res}; underflow flushes to +0, overflow (also after rounding) raises err.
  function automatic logic [32:0] round_pack(input logic sign, input logic signed [9:0] e,
                                             input logic [22:0] m, input logic gd, input logic st);
    logic              inc;
    logic [23:0]       sum;
    logic signed [9:0] e_r;
    inc = RNE & gd & (st | m[0]);
    sum = {1'b0, m} + {23'd0, inc};
    e_r = e + $signed({9'd0, sum[23]});
    if (e < 10'sd1)          round_pack = 33'd0;
    else if (e_r > 10'sd254) round_pack = {1'b1, 32'd0};
    else                     round_pack = {1'b0, sign, e_r[7:0], sum[22:0]};
  endfunction

  assign is_sqr = (op_p0 == OP_SQR);
  assign is_div = (op_p0 == OP_DIV);
  assign ex = x_p0[30:23];
  assign en = n_p0[30:23];
  assign mx = (ex == 8'd0) ? 24'd0 : {1'b1, x_p0[22:0]};
  assign mn = (en == 8'd0) ? 24'd0 : {1'b1, n_p0[22:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.r_i) state_nxt = UNPACK;
      UNPACK:  state_nxt = (is_sqr || is_div) ? ITER : PACK;
      ITER:    if (cnt_p1 == 5'd0) state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r_o_c  = (state == DONE);
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt_p1 <= 5'd0;
    else if (state == UNPACK)  cnt_p1 <= is_div ? 5'd25 : 5'd23;
    else if (state == ITER)    cnt_p1 <= cnt_p1 - 5'd1;
  end

  assign div_ge  = (rem_p1 >= {2'b00, dvsr_p1});
  assign div_rem = div_ge ? (rem_p1 - {2'b00, dvsr_p1}) : rem_p1;

  // Stage p0: operand capture; stage p1: unpack then one multiply/divide step per ITER cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.r_i) begin
      x_p0  <= bus.x;
      n_p0  <= bus.n;
      op_p0 <= bus.op;
    end
    if (state == UNPACK) begin
      sign_p1   <= is_div & (x_p0[31] ^ n_p0[31]);
      exp_p1    <= is_div ? ($signed({2'b00, ex}) - $signed({2'b00, en}) + 10'sd126)
                          : ($signed({2'b00, ex}) + $signed({2'b00, ex}) - 10'sd127);
      zero_p1   <= (ex == 8'd0);
      bad_p1    <= is_div ? (ex == 8'd255 || en == 8'd255 || en == 8'd0) : (ex == 8'd255);
      acc_p1    <= 48'd0;
      mcand_p1  <= {24'd0, mx};
      mplier_p1 <= mx;
      rem_p1    <= {2'b00, mx};
      quo_p1    <= 26'd0;
      dvsr_p1   <= mn;
    end else if (state == ITER) begin
      if (is_sqr) begin
        if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
        mcand_p1  <= mcand_p1 << 1;
        mplier_p1 <= mplier_p1 >> 1;
      end else begin
        rem_p1 <= {div_rem[24:0], 1'b0};
        quo_p1 <= {quo_p1[24:0], div_ge};
      end
    end
  end

  // Stage p2: normalize, round and pack
  always_comb begin
    if (is_sqr) begin
      hi   = acc_p1[47];
      mant = hi ? acc_p1[46:24] : acc_p1[45:23];
      g    = hi ? acc_p1[23] : acc_p1[22];
      s    = hi ? (|acc_p1[22:0]) : (|acc_p1[21:0]);
    end else begin
      hi   = quo_p1[25];
      mant = hi ? quo_p1[24:2] : quo_p1[23:1];
      g    = hi ? quo_p1[1] : quo_p1[0];
      s    = hi ? (quo_p1[0] | (|rem_p1)) : (|rem_p1);
    end
    e_n = exp_p1 + $signed({9'd0, hi});
    if (bad_p1)       pk = {1'b1, 32'd0};
    else if (zero_p1) pk = 33'd0;
    else              pk = round_pack(sign_p1, e_n, mant, g, s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q  <= 32'd0;
      frac_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == PACK) begin
      if (is_sqr || is_div) begin
        res_q  <= pk[31:0];
        err_q  <= pk[32];
        frac_q <= 1'b0;
      end else begin
        res_q  <= 32'd0;
        err_q  <= 1'b0;
        frac_q <= frac_of(n_p0[30:0]);
      end
    end
  end

  assign bus.res  = res_q;
  assign bus.frac = frac_q;
  assign bus.err  = err_q;
  assign bus.r_o  = r_o_c;
  assign bus.busy = busy_c;

endmodule

// File: tb/tb_fp_helper_unit.sv
// Directed scoreboard bench for fp_helper_unit (FRAC/SQR/DIV, handshake, async reset).
module tb_fp_helper_unit;
  logic clk = 1'b0;
  logic reset;

  fp_helper_unit_if bus();
  fp_helper_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef FP_HELPER_ROUND_NEAREST_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        frac;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] x, input logic [31:0] n);
    @(negedge clk);
    bus.r_i = 1'b1; bus.op = op; bus.x = x; bus.n = n;
    @(posedge clk); #1;
    bus.r_i = 1'b0; bus.op = 2'($urandom_range(3, 0)); bus.x = $urandom; bus.n = $urandom;
  endtask

  task automatic wait_done(input int start_cyc);
    exp_t e;
    int cyc = start_cyc;
    while (bus.r_o !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({e.tag, " res"}, bus.res, e.res);
    chk({e.tag, " frac"}, {31'd0, bus.frac}, {31'd0, e.frac});
    chk({e.tag, " err"}, {31'd0, bus.err}, {31'd0, e.err});
    chk({e.tag, " busy at done"}, {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    chk({e.tag, " r_o drop"}, {31'd0, bus.r_o}, 32'd0);
    chk({e.tag, " busy drop"}, {31'd0, bus.busy}, 32'd0);
    chk({e.tag, " res hold"}, bus.res, e.res);
  endtask

  task automatic push(input string tag, input logic [31:0] r, input logic f,
                      input logic er, input int lat);
    exp_t e;
    e.tag = tag; e.res = r; e.frac = f; e.err = er; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] x,
                     input logic [31:0] n, input logic [31:0] r, input logic f,
                     input logic er, input int lat);
    push(tag, r, f, er, lat);
    start(op, x, n);
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    wait_done(0);
  endtask

  task automatic no_r_o(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.r_o === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.r_i = 1'b0; bus.op = 2'b00; bus.x = 32'd0; bus.n = 32'd0;
    #12;
    chk("reset res",  bus.res, 32'd0);
    chk("reset frac", {31'd0, bus.frac}, 32'd0);
    chk("reset err",  {31'd0, bus.err}, 32'd0);
    chk("reset r_o",  {31'd0, bus.r_o}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); reset = 1'b1;

    run("frac 3.0",      2'b00, 32'h12345678, 32'h40400000, 32'd0, 1'b0, 1'b0, 2);
    run("frac 2.5",      2'b00, 32'h0,        32'h40200000, 32'd0, 1'b1, 1'b0, 2);
    run("frac 0.5",      2'b00, 32'h0,        32'h3F000000, 32'd0, 1'b1, 1'b0, 2);
    run("frac 0",        2'b00, 32'h0,        32'h00000000, 32'd0, 1'b0, 1'b0, 2);
    run("frac -2.5",     2'b00, 32'h0,        32'hC0200000, 32'd0, 1'b1, 1'b0, 2);
    run("frac op11",     2'b11, 32'h40400000, 32'h40200000, 32'd0, 1'b1, 1'b0, 2);
    run("frac inf",      2'b00, 32'h0,        32'h7F800000, 32'd0, 1'b1, 1'b0, 2);
    run("frac e150",     2'b00, 32'h0,        32'h4B000001, 32'd0, 1'b0, 1'b0, 2);
    run("frac e149",     2'b00, 32'h0,        32'h4AFFFFFF, 32'd1 - 32'd1, 1'b1, 1'b0, 2);

    run("sqr 3.0",       2'b01, 32'h40400000, 32'h0, 32'h41100000, 1'b0, 1'b0, 26);
    run("sqr 1.5",       2'b01, 32'h3FC00000, 32'h0, 32'h40100000, 1'b0, 1'b0, 26);
    run("sqr -2",        2'b01, 32'hC0000000, 32'h0, 32'h40800000, 1'b0, 1'b0, 26);
    run("sqr 1e20",      2'b01, 32'h60AD78EC, 32'h0, 32'h00000000, 1'b0, 1'b1, 26);
    run("sqr 0",         2'b01, 32'h00000000, 32'h0, 32'h00000000, 1'b0, 1'b0, 26);
    run("sqr denorm",    2'b01, 32'h00000001, 32'h0, 32'h00000000, 1'b0, 1'b0, 26);

    run("div 1/3",       2'b10, 32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b0, 28);
    run("div 5/0",       2'b10, 32'h40A00000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 28);
    run("div 10/-2",     2'b10, 32'h41200000, 32'hC0000000, 32'hC0A00000, 1'b0, 1'b0, 28);
    run("div 0/3",       2'b10, 32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 1'b0, 28);
    run("div ovf",       2'b10, 32'h7F000000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 28);
    run("div unf",       2'b10, 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 28);

    // Second start strobe in the middle of a square must be ignored
    push("sqr ignore r_i", 32'h41100000, 1'b0, 1'b0, 26);
    start(2'b01, 32'h40400000, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.r_i = 1'b1; bus.op = 2'b10; bus.x = 32'h3F800000; bus.n = 32'h40400000;
    @(posedge clk); #1;
    bus.r_i = 1'b0;
    wait_done(5);
    no_r_o("no second r_o", 40);

    // Asynchronous reset during a divide aborts it
    start(2'b10, 32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort res",  bus.res, 32'd0);
    chk("abort frac", {31'd0, bus.frac}, 32'd0);
    chk("abort err",  {31'd0, bus.err}, 32'd0);
    chk("abort r_o",  {31'd0, bus.r_o}, 32'd0);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    no_r_o("no r_o after abort", 40);

    run("div after reset", 2'b10, 32'h41200000, 32'hC0000000, 32'hC0A00000, 1'b0, 1'b0, 28);
    run("frac clears res", 2'b00, 32'h41200000, 32'h40200000, 32'd0, 1'b1, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
